// File: rtl/seg7_reader.sv
// seg7_reader
// Watches a time-multiplexed seven-segment bus, qualifies each digit by
// stability, decodes it back to BCD and publishes a full multi-digit frame
// once every position has been captured.
module seg7_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);
    localparam logic [3:0] RUN_CAP = 4'(STABLE_CYCLES - 2);

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [3:0]              run;
    logic                    armed;
    logic [NUM_DIGITS-1:0]   seen;
    logic [4*NUM_DIGITS-1:0] digit_r;
    logic [NUM_DIGITS-1:0]   err_r;

    logic                    same;
    logic                    sel_onehot;
    logic                    capture;
    logic [3:0]              dec_val;
    logic                    dec_bad;
    logic [4*NUM_DIGITS-1:0] digit_next;
    logic [NUM_DIGITS-1:0]   err_next;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic                    frame_done;

    assign same       = (seg == seg_q) && (dig_sel == sel_q);
    assign sel_onehot = $onehot(sel_q);
    assign capture    = same && (run == RUN_CAP) && armed && sel_onehot;

    // Map the registered segment pattern back to a BCD nibble
    always_comb begin
        dec_val = 4'hF;
        dec_bad = 1'b0;
        case (seg_q)
            7'b0111111: dec_val = 4'd0;
            7'b0000110: dec_val = 4'd1;
            7'b1011011: dec_val = 4'd2;
            7'b1001111: dec_val = 4'd3;
            7'b1100110: dec_val = 4'd4;
            7'b1101101: dec_val = 4'd5;
            7'b1111101: dec_val = 4'd6;
            7'b0000111: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1101111: dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_bad = 1'b1;
            end
        endcase
    end

    // Merge the digit being captured into the collected frame state
    always_comb begin
        digit_next = digit_r;
        err_next   = err_r;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
                digit_next[4*i +: 4] = dec_val;
                err_next[i]          = dec_bad;
            end
        end
        seen_next  = seen | sel_q;
        frame_done = capture && (&seen_next);
    end

    // Stability tracker: input pipeline, saturating run length, one-shot arm
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q <= '0;
            sel_q <= '0;
            run   <= '0;
            armed <= 1'b1;
        end else begin
            seg_q <= seg;
            sel_q <= dig_sel;
            if (same) begin
                run <= (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
            end else begin
                run <= '0;
            end
            // Re-arm on the same edge that clears run, so even a
            // two-sample qualification window sees armed=1 in time.
            if (!same) begin
                armed <= 1'b1;
            end else if (capture) begin
                armed <= 1'b0;
            end
        end
    end

    // Per-position capture registers and the seen mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen    <= '0;
            digit_r <= '0;
            err_r   <= '0;
        end else if (capture) begin
            digit_r <= digit_next;
            if (frame_done) begin
                seen  <= '0;
                err_r <= '0;
            end else begin
                seen  <= seen_next;
                err_r <= err_next;
            end
        end
    end

    // Publish a completed frame and hold it until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_out     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                bcd_out   <= digit_next;
                frame_err <= |err_next;
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed display scans checked against a
// sample-counting behavioural model plus literal frame expectations.
module tb_seg7_reader;

    localparam int ND = 4;
    localparam int SC = 3;

    logic            clk;
    logic            reset_n;
    logic [6:0]      seg;
    logic [ND-1:0]   dig_sel;
    logic [4*ND-1:0] bcd_out;
    logic            frame_valid;
    logic            frame_err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111};
    localparam logic [6:0] PAT_A = 7'b1110111;

    seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .seg(seg),
        .dig_sel(dig_sel),
        .bcd_out(bcd_out),
        .frame_valid(frame_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pair sampled SC consecutive times captures exactly once
    logic [6:0]      m_prev_seg;
    logic [ND-1:0]   m_prev_sel;
    int              m_cnt;
    logic [ND-1:0]   m_seen;
    logic [3:0]      m_dig [ND];
    logic            m_err [ND];
    logic [4*ND-1:0] exp_bcd;
    logic            exp_valid;
    logic            exp_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_prev_seg = '0;
            m_prev_sel = '0;
            m_cnt      = 1;
            m_seen     = '0;
            for (int i = 0; i < ND; i++) begin
                m_dig[i] = 4'h0;
                m_err[i] = 1'b0;
            end
            exp_bcd   = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else begin
            int idx;
            logic [3:0] v;
            logic bad;
            exp_valid = 1'b0;
            if (seg == m_prev_seg && dig_sel == m_prev_sel) m_cnt++;
            else m_cnt = 1;
            m_prev_seg = seg;
            m_prev_sel = dig_sel;
            if (m_cnt == SC && $countones(dig_sel) == 1) begin
                idx = 0;
                for (int i = 0; i < ND; i++) if (dig_sel[i]) idx = i;
                v = 4'hF;
                bad = 1'b1;
                for (int d = 0; d < 10; d++) begin
                    if (pat[d] == seg) begin
                        v = 4'(d);
                        bad = 1'b0;
                    end
                end
                m_dig[idx]  = v;
                m_err[idx]  = bad;
                m_seen[idx] = 1'b1;
                if (m_seen == {ND{1'b1}}) begin
                    exp_err = 1'b0;
                    for (int i = 0; i < ND; i++) begin
                        exp_bcd[4*i +: 4] = m_dig[i];
                        exp_err = exp_err | m_err[i];
                        m_err[i] = 1'b0;
                    end
                    exp_valid = 1'b1;
                    m_seen = '0;
                end
            end
        end
    end

    // Compare process: every falling edge
    always @(negedge clk) begin
        chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
        chk("frame_valid", 32'(frame_valid), 32'(exp_valid));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        if (frame_valid) pulses++;
    end

    // Drive a pair, starting at posedge+2, so it is sampled by n edges
    task automatic show(input logic [6:0] s, input logic [ND-1:0] sel, input int n);
        seg = s;
        dig_sel = sel;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic show_digit(input int pos, input logic [6:0] s);
        show(s, ND'(1 << pos), 5);
        show(7'b0, '0, 2);
    endtask

    task automatic scan(input int d0, input int d1, input int d2, input int d3);
        show_digit(0, pat[d0]);
        show_digit(1, pat[d1]);
        show_digit(2, pat[d2]);
        show_digit(3, pat[d3]);
    endtask

    initial begin
        reset_n = 1'b0;
        seg = '0;
        dig_sel = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        chk("reset_bcd", 32'(bcd_out), 32'h0);
        chk("reset_valid", 32'(frame_valid), 32'h0);
        chk("reset_err", 32'(frame_err), 32'h0);

        // Nominal scan
        scan(1, 2, 3, 4);
        chk("nominal_pulses", 32'(pulses), 32'd1);
        chk("nominal_bcd", 32'(bcd_out), 32'h4321);
        chk("nominal_err", 32'(frame_err), 32'h0);

        // Reset mid-frame discards partial collection
        show_digit(0, pat[5]);
        show_digit(1, pat[6]);
        show(pat[7], 4'b0100, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_bcd", 32'(bcd_out), 32'h0);
        chk("async_reset_err", 32'(frame_err), 32'h0);
        seg = '0;
        dig_sel = '0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        show_digit(0, pat[5]);
        show_digit(1, pat[6]);
        show(7'b0, '0, 6);
        chk("partial_no_pulse", 32'(pulses), 32'd1);
        show_digit(2, pat[7]);
        show_digit(3, pat[8]);
        chk("post_reset_pulses", 32'(pulses), 32'd2);
        chk("post_reset_bcd", 32'(bcd_out), 32'h8765);

        // Glitch rejection on position 2
        show_digit(0, pat[1]);
        show_digit(1, pat[2]);
        show(pat[7], 4'b0100, 2);
        show(pat[5], 4'b0100, 4);
        show(7'b0, '0, 2);
        show_digit(3, pat[4]);
        chk("glitch_pulses", 32'(pulses), 32'd3);
        chk("glitch_bcd", 32'(bcd_out), 32'h4521);

        // Illegal pattern, then a clean frame
        show_digit(0, pat[1]);
        show_digit(1, PAT_A);
        show_digit(2, pat[3]);
        show_digit(3, pat[4]);
        chk("illegal_bcd", 32'(bcd_out), 32'h43F1);
        chk("illegal_err", 32'(frame_err), 32'h1);
        scan(9, 0, 1, 2);
        chk("clean_bcd", 32'(bcd_out), 32'h2109);
        chk("clean_err", 32'(frame_err), 32'h0);
        chk("clean_pulses", 32'(pulses), 32'd5);

        // Recapture and multi-hot select
        show_digit(0, pat[3]);
        show_digit(0, pat[8]);
        show(pat[8], 4'b0110, 10);
        show(7'b0, '0, 2);
        chk("multihot_no_pulse", 32'(pulses), 32'd5);
        show_digit(1, pat[0]);
        show_digit(2, pat[0]);
        show_digit(3, pat[0]);
        chk("recapture_pulses", 32'(pulses), 32'd6);
        chk("recapture_bcd", 32'(bcd_out), 32'h0008);

        // Continuous scanning
        scan(0, 0, 0, 0);
        chk("cont1_bcd", 32'(bcd_out), 32'h0000);
        scan(9, 9, 9, 9);
        chk("cont2_bcd", 32'(bcd_out), 32'h9999);
        scan(0, 6, 0, 5);
        chk("cont3_bcd", 32'(bcd_out), 32'h5060);
        chk("cont_pulses", 32'(pulses), 32'd9);

        show(7'b0, '0, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
